// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, register-file channel states,
// and a constant-friendly clog2 used to size address decode fields.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_PEND = 2'b01,
    RD_RESP = 2'b10
  } rd_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Byte address to register index converter; low byte-lane bits are dropped
// and in_range flags indices that fall past the last register.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  in_range
);

  localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] word_addr;

  assign word_addr = addr >> ADDR_LSB;
  assign index     = word_addr[IDX_W-1:0];
  // Compare the full word address so high address bits cannot alias in range.
  assign in_range  = (word_addr < ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave register file: independent AW/W capture, one outstanding
// write and one outstanding read, byte-strobe writes and flat register export.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; ready/valid here are registered.

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_wr_decode (
    .addr    (aw_addr_q),
    .index   (wr_idx),
    .in_range(wr_in_range)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_rd_decode (
    .addr    (ar_addr_q),
    .index   (rd_idx),
    .in_range(rd_in_range)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    pulse_d    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (wr_state_q)
      WR_COLLECT: begin
        if (aw_held_q && w_held_q) begin
          // Commit one cycle after both halves are held.
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_in_range && (wr_idx == IDX_W'(i))) begin
              pulse_d[i] = 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) begin
                  regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
                end
              end
            end
          end
          bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_RESP;
        end else begin
          if (awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
          end
          if (wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          wr_state_d = WR_COLLECT;
        end
      end
      default: wr_state_d = WR_COLLECT;
    endcase

    bvalid_d  = (wr_state_d == WR_RESP);
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    ar_addr_d  = ar_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      RD_IDLE: begin
        if (arvalid && arready_q) begin
          ar_addr_d  = araddr;
          rd_state_d = RD_PEND;
        end
      end
      RD_PEND: begin
        // Sampled from regs_q, so a same-edge write commit is not visible.
        rdata_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rd_in_range && (rd_idx == IDX_W'(i))) begin
            rdata_d = regs_q[i];
          end
        end
        rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        rd_state_d = RD_RESP;
      end
      RD_RESP: begin
        if (rready) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    rvalid_d  = (rd_state_d == RD_RESP);
    arready_d = (rd_state_d == RD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      pulse_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_state_q <= RD_IDLE;
      ar_addr_q  <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign reg_wr_pulse = pulse_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Self-checking bench for axi_lite_slave_regfile: directed scenarios plus
// randomized traffic against an array model of the register file.
module tb_axi_lite_slave_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic               clk;
  logic               rst;
  logic [AW-1:0]      awaddr;
  logic               awvalid;
  logic               awready;
  logic [DW-1:0]      wdata;
  logic [DW/8-1:0]    wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [AW-1:0]      araddr;
  logic               arvalid;
  logic               arready;
  logic [DW-1:0]      rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;
  logic [NR*DW-1:0]   regs_out;
  logic [NR-1:0]      reg_wr_pulse;

  logic [DW-1:0] model [NR];
  int n_checks;
  int n_errors;

  axi_lite_slave_regfile #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .regs_out    (regs_out),
    .reg_wr_pulse(reg_wr_pulse)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check_val($sformatf("%s regs_out[%0d]", tag, i), 64'(regs_out[i*DW +: DW]), 64'(model[i]));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // Reference: byte address / 4 selects a word; strobed bytes replace model bytes.
  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [NR-1:0] pulse);
    longint unsigned idx;
    idx = longint'(addr) / 4;
    pulse = '0;
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      end
      resp = 2'b00;
      pulse[idx] = 1'b1;
    end else begin
      resp = 2'b10;
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
    longint unsigned idx;
    idx = longint'(addr) / 4;
    return (idx < NR) ? model[idx] : '0;
  endfunction

  // Driver: AW and W presented after independent delays, B held off b_stall cycles.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_stall);
    logic [1:0]    er;
    logic [NR-1:0] ep;
    bit aw_done;
    bit w_done;
    int cyc;
    int guard;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    guard   = 0;
    model_write(addr, data, strb, er, ep);
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (aw_done) check_val("awready_drop", 64'(awready), 64'd0);
      if (w_done)  check_val("wready_drop", 64'(wready), 64'd0);
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      cyc++;
      guard++;
      if (guard > 50) begin
        check_val("timeout_aw_w", 64'd0, 64'd1);
        break;
      end
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_val("awready_held", 64'(awready), 64'd0);
    check_val("wready_held", 64'(wready), 64'd0);
    guard = 0;
    while (!bvalid) begin
      check_val("pulse_idle", 64'(reg_wr_pulse), 64'd0);
      @(negedge clk);
      guard++;
      if (guard > 20) begin
        check_val("timeout_bvalid", 64'd0, 64'd1);
        break;
      end
    end
    check_val("bresp", 64'(bresp), 64'(er));
    check_val("pulse_commit", 64'(reg_wr_pulse), 64'(ep));
    check_regs("after_commit");
    for (int s = 0; s < b_stall; s++) begin
      @(negedge clk);
      check_val("bvalid_stall", 64'(bvalid), 64'd1);
      check_val("bresp_stall", 64'(bresp), 64'(er));
      check_val("awready_stall", 64'(awready), 64'd0);
      check_val("wready_stall", 64'(wready), 64'd0);
      check_val("pulse_stall", 64'(reg_wr_pulse), 64'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("bvalid_done", 64'(bvalid), 64'd0);
    check_val("pulse_done", 64'(reg_wr_pulse), 64'd0);
    check_val("awready_back", 64'(awready), 64'd1);
    check_val("wready_back", 64'(wready), 64'd1);
  endtask

  // Driver: AR handshake, R held off r_stall cycles; returns the R payload.
  task automatic axi_read(input logic [AW-1:0] addr, input int r_stall,
                          output logic [DW-1:0] data, output logic [1:0] resp);
    int guard;
    guard = 0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = addr;
    while (!arready) begin
      @(negedge clk);
      guard++;
      if (guard > 20) begin
        check_val("timeout_arready", 64'd0, 64'd1);
        break;
      end
    end
    @(negedge clk);
    arvalid = 1'b0;
    check_val("arready_drop", 64'(arready), 64'd0);
    guard = 0;
    while (!rvalid) begin
      @(negedge clk);
      guard++;
      if (guard > 20) begin
        check_val("timeout_rvalid", 64'd0, 64'd1);
        break;
      end
    end
    data = rdata;
    resp = rresp;
    for (int s = 0; s < r_stall; s++) begin
      @(negedge clk);
      check_val("rvalid_stall", 64'(rvalid), 64'd1);
      check_val("rdata_stall", 64'(rdata), 64'(data));
      check_val("rresp_stall", 64'(rresp), 64'(resp));
      check_val("arready_stall", 64'(arready), 64'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_val("rvalid_done", 64'(rvalid), 64'd0);
    check_val("arready_back", 64'(arready), 64'd1);
  endtask

  task automatic read_expect(input string tag, input logic [AW-1:0] addr, input int r_stall);
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [DW-1:0] ed;
    logic [1:0]    er;
    ed = model_read(addr);
    er = ((longint'(addr) / 4) < NR) ? 2'b00 : 2'b10;
    axi_read(addr, r_stall, d, r);
    check_val({tag, "_rdata"}, 64'(d), 64'(ed));
    check_val({tag, "_rresp"}, 64'(r), 64'(er));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_awready"}, 64'(awready), 64'd0);
    check_val({tag, "_wready"}, 64'(wready), 64'd0);
    check_val({tag, "_arready"}, 64'(arready), 64'd0);
    check_val({tag, "_bvalid"}, 64'(bvalid), 64'd0);
    check_val({tag, "_bresp"}, 64'(bresp), 64'd0);
    check_val({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    check_val({tag, "_rdata"}, 64'(rdata), 64'd0);
    check_val({tag, "_rresp"}, 64'(rresp), 64'd0);
    check_val({tag, "_pulse"}, 64'(reg_wr_pulse), 64'd0);
    check_regs(tag);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [DW-1:0] pre;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst_aw", 64'(awready), 64'd1);
    check_val("ready_after_rst_w", 64'(wready), 64'd1);
    check_val("ready_after_rst_ar", 64'(arready), 64'd1);

    // Basic full-word write and read back
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h08, 0, d, r);
    check_val("basic_rdata", 64'(d), 64'h0000_0000_DEAD_BEEF);
    check_val("basic_rresp", 64'(r), 64'd0);

    // Byte-strobe merge
    axi_write(32'h04, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(32'h04, 0, d, r);
    check_val("strb_merge", 64'(d), 64'h0000_0000_11BB_33DD);

    // W well ahead of AW
    axi_write(32'h0C, 32'h5, 4'hF, 3, 0, 0);
    check_val("w_first_reg3", 64'(regs_out[3*DW +: DW]), 64'h5);
    // AW ahead of W, with ignored low address bits
    axi_write(32'h1B, 32'hCAFEF00D, 4'hF, 0, 2, 0);

    // Out of range write and read
    axi_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
    read_expect("oor", 32'h40, 0);
    axi_write(32'h8000_0008, 32'h0BAD0BAD, 4'hF, 1, 0, 0);

    // Zero strobes still pulse and respond OKAY
    axi_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);

    // Backpressure on B and R
    axi_write(32'h10, 32'h600DD00D, 4'hF, 0, 0, 5);
    read_expect("rstall", 32'h10, 4);

    // Same-edge read and commit return the old value
    axi_write(32'h14, 32'h01010101, 4'hF, 0, 0, 0);
    pre = model[5];
    fork
      axi_write(32'h14, 32'hF0F0F0F0, 4'hF, 0, 0, 0);
      axi_read(32'h14, 0, d, r);
    join
    check_val("collision_old", 64'(d), 64'(pre));
    read_expect("collision_new", 32'h14, 0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(0, NR + 3) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        read_expect("rand", a, $urandom_range(0, 2));
      end
    end

    // Reset in the middle of a held AW and an unaccepted R
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = 32'h08;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check_val("mid_rvalid", 64'(rvalid), 64'd1);
    awvalid = 1'b1;
    awaddr  = 32'h00;
    @(negedge clk);
    awvalid = 1'b0;
    check_val("mid_aw_held", 64'(awready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    check_all_zero("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_aw", 64'(awready), 64'd1);
    check_val("post_rst_w", 64'(wready), 64'd1);
    check_val("post_rst_ar", 64'(arready), 64'd1);
    check_val("post_rst_rvalid", 64'(rvalid), 64'd0);
    axi_write(32'h14, 32'h7777AAAA, 4'hF, 2, 0, 0);
    read_expect("post_rst", 32'h14, 0);
    read_expect("post_rst0", 32'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
